sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Top-level command scheduler for the SDRAM controller. Owns the single SDRAM command/address bus.
- Holds off all traffic until initialization finishes, then grants the bus to one of three engines: auto-refresh, write and read.
- Drives each engine's enable and muxes the selected engine's cmd/ba/addr onto the SDRAM pins.
- Sits between sdram_init, sdram_aref, sdram_write and sdram_read, and the SDRAM device.

Parameters:
- CMD_W, 4, command width, encoding {cs_n,ras_n,cas_n,we_n}.
- ADDR_W, 12, SDRAM address width.
- BA_W, 2, bank address width.
- WR_STREAK_MAX, 4, consecutive write grants allowed while rd_req is pending before read is forced.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous active-high reset.
- init_end  in  1  init sequence complete; level input, stays high.
- init_cmd/init_ba/init_addr  in  CMD_W/BA_W/ADDR_W  init engine bus.
- aref_req  in  1  refresh due.
- aref_end  in  1  one-cycle pulse, refresh sequence done.
- aref_cmd/aref_ba/aref_addr  in  CMD_W/BA_W/ADDR_W  refresh engine bus.
- wr_req  in  1  write pending.
- wr_end  in  1  one-cycle pulse, write burst done.
- wr_cmd/wr_ba/wr_addr  in  CMD_W/BA_W/ADDR_W  write engine bus.
- rd_req  in  1  read pending.
- rd_end  in  1  one-cycle pulse, read burst done.
- rd_cmd/rd_ba/rd_addr  in  CMD_W/BA_W/ADDR_W  read engine bus.
- aref_en  out  1  refresh grant.
- wr_en  out  1  write grant.
- rd_en  out  1  read grant.
- sdram_cke  out  1  clock enable.
- sdram_cs_n/sdram_ras_n/sdram_cas_n/sdram_we_n  out  1 each  command pins.
- sdram_ba  out  BA_W  bank address.
- sdram_addr  out  ADDR_W  row/column address.

Behaviour:
- One clock, sys_clk. Reset sys_rst is synchronous and active-high.
- Reset values:
  - state=INIT.
  - aref_en=wr_en=rd_en=0.
  - wr_streak=0.
  - sdram_cke=1.
- FSM states: INIT, ARBIT, AREF, WRITE, READ.
- INIT:
  - Pins carry init_* unchanged.
  - Moves to ARBIT on the cycle after init_end is sampled high.
- ARBIT:
  - Pins carry NOP (4'b0111), ba=0, addr=0.
  - Evaluates requests every cycle and picks one winner by priority:
    1. aref_req.
    2. rd_req, if wr_streak==WR_STREAK_MAX.
    3. wr_req.
    4. rd_req.
  - No request: stays in ARBIT.
- Grant, registered: on the ARBIT cycle that picks a winner, the next state is AREF, WRITE or READ. The matching *_en goes high in that same next cycle (1-cycle grant latency).
- Grant exclusivity: at most one *_en is high in any cycle. This is a required invariant.
- AREF:
  - aref_en stays high and pins carry aref_* combinationally.
  - On aref_end: aref_en=0 next cycle and state returns to ARBIT.
- WRITE:
  - wr_en stays high and pins carry wr_*.
  - On wr_end: wr_en=0 next cycle and state returns to ARBIT.
  - On that exit: wr_streak increments (saturating at WR_STREAK_MAX) if rd_req is high; otherwise wr_streak=0.
- READ:
  - rd_en stays high and pins carry rd_*.
  - On rd_end: rd_en=0 next cycle, wr_streak=0, state returns to ARBIT.
- No preemption. A refresh request raised during WRITE/READ waits until that engine's *_end pulse. It then wins the very next ARBIT cycle, even over a forced read.
- Minimum one ARBIT (NOP) cycle between any two grants.
- Boundary cases:
  - *_end asserted in a state that does not own it: ignored.
  - aref_req, wr_req and rd_req all arriving in the same cycle: refresh wins.
  - Requests while in INIT: ignored; they are re-evaluated in ARBIT.
  - Synchronous reset mid-grant: next cycle all *_en=0, state=INIT, pins carry init_*. Engines are reset by the same sys_rst.
- sdram_cke is constant 1 after reset. Power-down is out of scope.

Decomposition:
- Shared package sdram_pkg holds:
  - Command constants: CMD_NOP=4'b0111, CMD_PRE=4'b0010, CMD_AREF=4'b0001, CMD_MRS=4'b0000, CMD_ACT=4'b0011, CMD_WR=4'b0100, CMD_RD=4'b0101.
  - State enum arb_state_t {INIT, ARBIT, AREF, WRITE, READ}.
  - Width constants.
- One natural sub-module, sdram_cmd_mux: a combinational select of cmd/ba/addr by state, splitting cmd into the four pin signals.

Test Plan:
- Reset and init: assert sys_rst 3 cycles, hold init_end=0 -> all *_en=0 and pins track init_*. Raise init_end -> state ARBIT one cycle later, pins={cs,ras,cas,we}=0111.
- Single refresh: aref_req=1 in ARBIT -> aref_en=1 next cycle, pins follow aref_*. Pulse aref_end -> aref_en=0 next cycle, NOP restored.
- Simultaneous requests: aref_req=wr_req=rd_req=1 in the same cycle -> grant order is aref, then write, then read. At least one NOP cycle between grants; never two *_en high together.
- Starvation guard (WR_STREAK_MAX=4): hold wr_req=1 and rd_req=1 continuously -> exactly 4 write grants, then 1 read grant, then writes resume.
- Refresh during burst: raise aref_req mid-WRITE -> wr_en is held until wr_end; aref_en is granted on the cycle after the ARBIT cycle that follows wr_end.
- Reset mid-READ: assert sys_rst while rd_en=1 -> next cycle rd_en=0, state INIT, wr_streak=0.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, arbiter state type and bus widths
package sdram_pkg;

    localparam int CMD_WIDTH  = 4;
    localparam int BA_WIDTH   = 2;
    localparam int ADDR_WIDTH = 12;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        INIT,
        ARBIT,
        AREF,
        WRITE,
        READ
    } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - engine request/grant/bus signals and SDRAM pins around the arbiter
// slave  : arbiter side (takes engine buses and requests, drives grants and pins)
// master : engine/device side (drives engine buses and requests, observes grants and pins)
interface sdram_arbiter_if
    import sdram_pkg::*;
#(
    parameter int CMD_W  = CMD_WIDTH,
    parameter int BA_W   = BA_WIDTH,
    parameter int ADDR_W = ADDR_WIDTH
) ();

    logic              init_end;
    logic [CMD_W-1:0]  init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;

    logic              aref_req;
    logic              aref_end;
    logic [CMD_W-1:0]  aref_cmd;
    logic [BA_W-1:0]   aref_ba;
    logic [ADDR_W-1:0] aref_addr;

    logic              wr_req;
    logic              wr_end;
    logic [CMD_W-1:0]  wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;

    logic              rd_req;
    logic              rd_end;
    logic [CMD_W-1:0]  rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;

    logic              aref_en;
    logic              wr_en;
    logic              rd_en;

    logic              sdram_cke;
    logic              sdram_cs_n;
    logic              sdram_ras_n;
    logic              sdram_cas_n;
    logic              sdram_we_n;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr
    );

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr
    );

endinterface

// File: rtl/sdram_cmd_mux.sv
// rtl/sdram_cmd_mux.sv - selects the owning engine's cmd/ba/addr by arbiter state
// in : state, init_*/aref_*/wr_*/rd_* cmd/ba/addr
// out: cs_n/ras_n/cas_n/we_n split from cmd, ba, addr (NOP with zero ba/addr in ARBIT)
module sdram_cmd_mux
    import sdram_pkg::*;
#(
    parameter int CMD_W  = CMD_WIDTH,
    parameter int BA_W   = BA_WIDTH,
    parameter int ADDR_W = ADDR_WIDTH
) (
    input  arb_state_t        state,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [CMD_W-1:0]  aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              cs_n,
    output logic              ras_n,
    output logic              cas_n,
    output logic              we_n,
    output logic [BA_W-1:0]   ba,
    output logic [ADDR_W-1:0] addr
);

    logic [CMD_W-1:0] cmd;

    always_comb begin
        cmd  = CMD_W'(CMD_NOP);
        ba   = '0;
        addr = '0;
        case (state)
            INIT: begin
                cmd  = init_cmd;
                ba   = init_ba;
                addr = init_addr;
            end
            AREF: begin
                cmd  = aref_cmd;
                ba   = aref_ba;
                addr = aref_addr;
            end
            WRITE: begin
                cmd  = wr_cmd;
                ba   = wr_ba;
                addr = wr_addr;
            end
            READ: begin
                cmd  = rd_cmd;
                ba   = rd_ba;
                addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd;

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM command bus scheduler: init hold-off, then refresh/write/read grants
// sys_clk, sys_rst : clock and synchronous active-high reset
// bus (slave)      : engine buses/requests/end pulses in; aref_en/wr_en/rd_en and SDRAM pins out
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int WR_STREAK_MAX = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    sdram_arbiter_if.slave bus
);

    localparam int STREAK_W = $clog2(WR_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_FULL = STREAK_W'(WR_STREAK_MAX);

    arb_state_t          state, state_nxt;
    logic [STREAK_W-1:0] wr_streak, wr_streak_nxt;
    logic                aref_en_q, aref_en_nxt;
    logic                wr_en_q, wr_en_nxt;
    logic                rd_en_q, rd_en_nxt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= INIT;
            wr_streak <= '0;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_streak <= wr_streak_nxt;
            aref_en_q <= aref_en_nxt;
            wr_en_q   <= wr_en_nxt;
            rd_en_q   <= rd_en_nxt;
        end
    end

    // Grants are registered alongside the state, so each *_en rises in the
    // first cycle of its state and only one can ever be high.
    always_comb begin
        state_nxt     = state;
        wr_streak_nxt = wr_streak;
        aref_en_nxt   = aref_en_q;
        wr_en_nxt     = wr_en_q;
        rd_en_nxt     = rd_en_q;
        case (state)
            INIT: begin
                if (bus.init_end) state_nxt = ARBIT;
            end
            ARBIT: begin
                if (bus.aref_req) begin
                    state_nxt   = AREF;
                    aref_en_nxt = 1'b1;
                end else if (bus.rd_req && wr_streak == STREAK_FULL) begin
                    // a read has waited behind a full streak of writes
                    state_nxt = READ;
                    rd_en_nxt = 1'b1;
                end else if (bus.wr_req) begin
                    state_nxt = WRITE;
                    wr_en_nxt = 1'b1;
                end else if (bus.rd_req) begin
                    state_nxt = READ;
                    rd_en_nxt = 1'b1;
                end
            end
            AREF: begin
                if (bus.aref_end) begin
                    state_nxt   = ARBIT;
                    aref_en_nxt = 1'b0;
                end
            end
            WRITE: begin
                if (bus.wr_end) begin
                    state_nxt = ARBIT;
                    wr_en_nxt = 1'b0;
                    // only writes that overtook a waiting read count toward the streak
                    if (!bus.rd_req)                   wr_streak_nxt = '0;
                    else if (wr_streak != STREAK_FULL) wr_streak_nxt = wr_streak + 1'b1;
                end
            end
            READ: begin
                if (bus.rd_end) begin
                    state_nxt     = ARBIT;
                    rd_en_nxt     = 1'b0;
                    wr_streak_nxt = '0;
                end
            end
            default: begin
                state_nxt   = INIT;
                aref_en_nxt = 1'b0;
                wr_en_nxt   = 1'b0;
                rd_en_nxt   = 1'b0;
            end
        endcase
    end

    assign bus.aref_en   = aref_en_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.sdram_cke = 1'b1;

    sdram_cmd_mux #(
        .CMD_W  ($bits(bus.init_cmd)),
        .BA_W   ($bits(bus.init_ba)),
        .ADDR_W ($bits(bus.init_addr))
    ) u_cmd_mux (
        .state     (state),
        .init_cmd  (bus.init_cmd),
        .init_ba   (bus.init_ba),
        .init_addr (bus.init_addr),
        .aref_cmd  (bus.aref_cmd),
        .aref_ba   (bus.aref_ba),
        .aref_addr (bus.aref_addr),
        .wr_cmd    (bus.wr_cmd),
        .wr_ba     (bus.wr_ba),
        .wr_addr   (bus.wr_addr),
        .rd_cmd    (bus.rd_cmd),
        .rd_ba     (bus.rd_ba),
        .rd_addr   (bus.rd_addr),
        .cs_n      (bus.sdram_cs_n),
        .ras_n     (bus.sdram_ras_n),
        .cas_n     (bus.sdram_cas_n),
        .we_n      (bus.sdram_we_n),
        .ba        (bus.sdram_ba),
        .addr      (bus.sdram_addr)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter with a behavioural bus-ownership model
module tb_sdram_arbiter;

    localparam int MAXS   = 4;
    localparam int O_NONE = 0;
    localparam int O_AREF = 1;
    localparam int O_WR   = 2;
    localparam int O_RD   = 3;

    localparam logic [17:0] PINS_NOP  = {4'b0111, 2'd0, 12'h000};
    localparam logic [17:0] PINS_INIT = {4'b0010, 2'd0, 12'h400};
    localparam logic [17:0] PINS_AREF = {4'b0001, 2'd0, 12'h000};

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    sdram_arbiter_if bus ();

    sdram_arbiter #(.WR_STREAK_MAX(MAXS)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;
    int order[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] en_vec();
        return {bus.aref_en, bus.wr_en, bus.rd_en};
    endfunction

    function automatic logic [17:0] pins();
        return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
                bus.sdram_ba, bus.sdram_addr};
    endfunction

    // Model: who owns the bus, whether init is done, and how many writes
    // in a row have overtaken a waiting read.
    bit m_valid = 0;
    bit m_ready = 0;
    int m_owner = O_NONE;
    int m_streak = 0;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_valid  = 1;
            m_ready  = 0;
            m_owner  = O_NONE;
            m_streak = 0;
        end else if (!m_ready) begin
            m_ready = bus.init_end;
        end else begin
            case (m_owner)
                O_NONE: begin
                    if (bus.aref_req)                        m_owner = O_AREF;
                    else if (bus.rd_req && m_streak == MAXS) m_owner = O_RD;
                    else if (bus.wr_req)                     m_owner = O_WR;
                    else if (bus.rd_req)                     m_owner = O_RD;
                end
                O_AREF: if (bus.aref_end) m_owner = O_NONE;
                O_WR: if (bus.wr_end) begin
                    m_owner  = O_NONE;
                    m_streak = bus.rd_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                end
                O_RD: if (bus.rd_end) begin
                    m_owner  = O_NONE;
                    m_streak = 0;
                end
                default: m_owner = O_NONE;
            endcase
        end
    end

    logic [2:0]  exp_en;
    logic [17:0] exp_pins;

    always @(negedge sys_clk) begin
        if (m_valid) begin
            exp_en = {m_owner == O_AREF, m_owner == O_WR, m_owner == O_RD};
            if (!m_ready)               exp_pins = {bus.init_cmd, bus.init_ba, bus.init_addr};
            else if (m_owner == O_AREF) exp_pins = {bus.aref_cmd, bus.aref_ba, bus.aref_addr};
            else if (m_owner == O_WR)   exp_pins = {bus.wr_cmd, bus.wr_ba, bus.wr_addr};
            else if (m_owner == O_RD)   exp_pins = {bus.rd_cmd, bus.rd_ba, bus.rd_addr};
            else                        exp_pins = PINS_NOP;
            check("model_en", en_vec(), exp_en);
            check("model_pins", pins(), exp_pins);
            check("exclusive", $countones(en_vec()) <= 1, 1);
            check("cke", bus.sdram_cke, 1);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_en(input string name, input logic [2:0] target);
        int n = 0;
        while (en_vec() != target && n < 20) begin
            tick();
            n++;
        end
        check(name, en_vec(), target);
    endtask

    // Acts as all three engines: records each new grant, optionally drops
    // that request, and ends the burst after three granted cycles.
    task automatic serve(input int n_grants, input bit drop);
        int got = 0;
        int hold = 0;
        int cur = 0;
        int budget = 0;
        do begin
            tick();
            budget++;
            bus.aref_end = 0;
            bus.wr_end   = 0;
            bus.rd_end   = 0;
            cur = bus.aref_en ? O_AREF : bus.wr_en ? O_WR : bus.rd_en ? O_RD : O_NONE;
            if (cur == O_NONE) begin
                hold = 0;
            end else begin
                hold++;
                if (hold == 1) begin
                    order.push_back(cur);
                    got++;
                    if (drop) begin
                        if (cur == O_AREF) bus.aref_req = 0;
                        if (cur == O_WR)   bus.wr_req   = 0;
                        if (cur == O_RD)   bus.rd_req   = 0;
                    end
                end
                if (hold == 3) begin
                    if (cur == O_AREF) bus.aref_end = 1;
                    if (cur == O_WR)   bus.wr_end   = 1;
                    if (cur == O_RD)   bus.rd_end   = 1;
                end
            end
        end while ((got < n_grants || cur != O_NONE) && budget < 400);
        check("serve_grants", got, n_grants);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1);
    end

    initial begin
        bus.init_end = 0; bus.init_cmd = 4'b0010; bus.init_ba = 2'd0; bus.init_addr = 12'h400;
        bus.aref_req = 0; bus.aref_end = 0; bus.aref_cmd = 4'b0001; bus.aref_ba = 2'd0; bus.aref_addr = 12'h000;
        bus.wr_req = 0; bus.wr_end = 0; bus.wr_cmd = 4'b0100; bus.wr_ba = 2'd1; bus.wr_addr = 12'h055;
        bus.rd_req = 0; bus.rd_end = 0; bus.rd_cmd = 4'b0101; bus.rd_ba = 2'd2; bus.rd_addr = 12'h0AA;
        sys_rst = 1;
        repeat (3) tick();
        settle();
        check("rst_en", en_vec(), 3'b000);
        check("rst_pins", pins(), PINS_INIT);

        // requests during INIT are held off
        sys_rst = 0;
        bus.aref_req = 1;
        tick(); settle();
        check("init_ignores_req", en_vec(), 3'b000);
        check("init_pins", pins(), PINS_INIT);
        bus.init_end = 1;
        tick(); settle();
        check("arbit_en", en_vec(), 3'b000);
        check("arbit_nop", pins(), PINS_NOP);
        tick(); settle();
        check("aref_grant", en_vec(), 3'b100);
        check("aref_pins", pins(), PINS_AREF);
        bus.aref_req = 0;
        bus.wr_end = 1;
        tick(); bus.wr_end = 0; settle();
        check("foreign_end_ignored", en_vec(), 3'b100);
        bus.aref_end = 1;
        tick(); bus.aref_end = 0; settle();
        check("aref_release", en_vec(), 3'b000);
        check("aref_release_nop", pins(), PINS_NOP);

        // simultaneous requests
        bus.aref_req = 1; bus.wr_req = 1; bus.rd_req = 1;
        order.delete();
        serve(3, 1);
        check("simul_n", order.size(), 3);
        if (order.size() == 3) begin
            check("simul_0", order[0], O_AREF);
            check("simul_1", order[1], O_WR);
            check("simul_2", order[2], O_RD);
        end

        // starvation guard
        bus.wr_req = 1; bus.rd_req = 1;
        order.delete();
        serve(6, 0);
        bus.wr_req = 0; bus.rd_req = 0;
        check("starve_n", order.size(), 6);
        if (order.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("starve_%0d", i), order[i], (i == 4) ? O_RD : O_WR);
        end

        // refresh raised during a write burst
        bus.wr_req = 1;
        tick();
        wait_en("wr_granted", 3'b010);
        bus.aref_req = 1;
        repeat (3) begin
            tick();
            check("wr_held", en_vec(), 3'b010);
        end
        bus.wr_end = 1;
        tick(); bus.wr_end = 0; settle();
        check("wr_exit", en_vec(), 3'b000);
        check("wr_exit_nop", pins(), PINS_NOP);
        tick(); settle();
        check("aref_after_burst", en_vec(), 3'b100);
        bus.aref_req = 0; bus.wr_req = 0;
        serve(1, 1);

        // reset mid-read
        bus.rd_req = 1;
        tick();
        wait_en("rd_granted", 3'b001);
        sys_rst = 1;
        bus.rd_req = 0;
        tick(); settle();
        check("rst_mid_read_en", en_vec(), 3'b000);
        check("rst_mid_read_pins", pins(), PINS_INIT);
        sys_rst = 0;
        tick(); settle();
        check("reinit_arbit", pins(), PINS_NOP);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 2000; c++) begin
            tick();
            sys_rst = ($urandom_range(0, 199) == 0);
            if (sys_rst) bus.init_end = 0;
            else if (!bus.init_end && $urandom_range(0, 3) == 0) bus.init_end = 1;
            bus.aref_req  = ($urandom_range(0, 9) < 2);
            bus.wr_req    = ($urandom_range(0, 9) < 7);
            bus.rd_req    = ($urandom_range(0, 9) < 6);
            bus.aref_end  = ($urandom_range(0, 3) == 0);
            bus.wr_end    = ($urandom_range(0, 3) == 0);
            bus.rd_end    = ($urandom_range(0, 3) == 0);
            bus.init_cmd  = 4'($urandom); bus.init_ba = 2'($urandom); bus.init_addr = 12'($urandom);
            bus.aref_cmd  = 4'($urandom); bus.aref_ba = 2'($urandom); bus.aref_addr = 12'($urandom);
            bus.wr_cmd    = 4'($urandom); bus.wr_ba   = 2'($urandom); bus.wr_addr   = 12'($urandom);
            bus.rd_cmd    = 4'($urandom); bus.rd_ba   = 2'($urandom); bus.rd_addr   = 12'($urandom);
        end
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
